// File: rtl/cpu_phase_sequencer_if.sv
// Signal bundle between the phase sequencer and the processor blocks it drives.
// MW requests a memory phase, and a single-cycle mem_ack pulse closes that phase.
interface cpu_phase_sequencer_if;
  logic       dclk;
  logic       MW;
  logic       mem_ack;
  logic       halt;
  logic [2:0] phase;
  logic       fetch_en;
  logic       decode_en;
  logic       exec_en;
  logic       mem_en;
  logic       wb_en;
  logic       busy;
  logic [7:0] instr_count;

  modport master (
    output dclk, MW, mem_ack, halt,
    input  phase, fetch_en, decode_en, exec_en, mem_en, wb_en, busy, instr_count
  );

  modport slave (
    input  dclk, MW, mem_ack, halt,
    output phase, fetch_en, decode_en, exec_en, mem_en, wb_en, busy, instr_count
  );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// Steps the processor through fetch/decode/exec/mem/wb on rising edges of the
// divided clock, emitting one-cycle phase enables in the fast clock domain.
module cpu_phase_sequencer #(
  parameter int unsigned STARTUP_TICKS = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  cpu_phase_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALTED  = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [3:0] LAST_STARTUP = 4'(STARTUP_TICKS - 1);

  // Strobe vector layout: {fetch, decode, exec, mem, wb}.
  localparam logic [4:0] STB_FETCH  = 5'b10000;
  localparam logic [4:0] STB_DECODE = 5'b01000;
  localparam logic [4:0] STB_EXEC   = 5'b00100;
  localparam logic [4:0] STB_MEM    = 5'b00010;
  localparam logic [4:0] STB_WB     = 5'b00001;

  state_t     r_state;
  state_t     w_next;
  logic       r_dclk_q;
  logic       w_tick;
  logic [3:0] r_start_cnt;
  logic [3:0] w_start_cnt;
  logic       r_ack_seen;
  logic       w_ack_seen;
  logic [7:0] r_count;
  logic [7:0] w_count;
  logic [4:0] r_strobe;
  logic [4:0] w_strobe;

  // dclk_q resets high so a level already high at reset release is not a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dclk_q <= 1'b1;
    end else begin
      r_dclk_q <= bus.dclk;
    end
  end

  assign w_tick = bus.dclk & ~r_dclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET;
      r_start_cnt <= '0;
      r_ack_seen  <= 1'b0;
      r_count     <= '0;
      r_strobe    <= '0;
    end else begin
      r_state     <= w_next;
      r_start_cnt <= w_start_cnt;
      r_ack_seen  <= w_ack_seen;
      r_count     <= w_count;
      r_strobe    <= w_strobe;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start_cnt = r_start_cnt;
    w_ack_seen  = r_ack_seen;
    w_count     = r_count;
    w_strobe    = '0;
    case (r_state)
      S_RESET: begin
        if (w_tick) begin
          if (r_start_cnt == LAST_STARTUP) begin
            w_next      = S_FETCH;
            w_start_cnt = '0;
            w_strobe    = STB_FETCH;
          end else begin
            w_start_cnt = r_start_cnt + 4'd1;
          end
        end
      end
      S_FETCH: begin
        if (w_tick) begin
          w_next   = S_DECODE;
          w_strobe = STB_DECODE;
        end
      end
      S_DECODE: begin
        if (w_tick) begin
          w_next   = S_EXEC;
          w_strobe = STB_EXEC;
        end
      end
      S_EXEC: begin
        if (w_tick) begin
          if (bus.MW) begin
            w_next   = S_MEM;
            w_strobe = STB_MEM;
          end else begin
            w_next   = S_WB;
            w_strobe = STB_WB;
          end
        end
      end
      S_MEM: begin
        // An ack arriving between ticks is remembered until the next tick.
        if (bus.mem_ack) begin
          w_ack_seen = 1'b1;
        end
        if (w_tick && (r_ack_seen || bus.mem_ack)) begin
          w_next     = S_WB;
          w_ack_seen = 1'b0;
          w_strobe   = STB_WB;
        end
      end
      S_WB: begin
        if (w_tick) begin
          w_count = r_count + 8'd1;
          if (bus.halt) begin
            w_next = S_HALTED;
          end else begin
            w_next   = S_FETCH;
            w_strobe = STB_FETCH;
          end
        end
      end
      S_HALTED: begin
        if (w_tick && !bus.halt) begin
          w_next   = S_FETCH;
          w_strobe = STB_FETCH;
        end
      end
      default: begin
        w_next      = S_RESET;
        w_start_cnt = '0;
        w_ack_seen  = 1'b0;
      end
    endcase
  end

  assign bus.phase       = r_state;
  assign bus.fetch_en    = r_strobe[4];
  assign bus.decode_en   = r_strobe[3];
  assign bus.exec_en     = r_strobe[2];
  assign bus.mem_en      = r_strobe[1];
  assign bus.wb_en       = r_strobe[0];
  assign bus.busy        = (r_state != S_RESET) && (r_state != S_HALTED);
  assign bus.instr_count = r_count;

  a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_strobe));

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: directed vector table, random instruction
// plans checked against an instruction-level phase model, and reset corners.
module tb_cpu_phase_sequencer;

  logic clk;
  logic rst_n;

  cpu_phase_sequencer_if bus ();

  cpu_phase_sequencer #(.STARTUP_TICKS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mw;
    int         ack;
    logic       hlt;
    logic [2:0] ph;
    int         cnt;
  } vec_t;

  vec_t       tbl[$];
  logic [2:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_done  = 0;
  logic [2:0] m_phase = 3'd0;

  task automatic chk(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en};
  endfunction

  // Entering a new phase fires its enable; staying put or RESET/HALTED fires none.
  function automatic logic [4:0] exp_strobe(input logic [2:0] prev, input logic [2:0] nxt);
    logic [4:0] s;
    s = 5'b00000;
    if (prev != nxt) begin
      case (nxt)
        3'd1: s = 5'b10000;
        3'd2: s = 5'b01000;
        3'd3: s = 5'b00100;
        3'd4: s = 5'b00010;
        3'd5: s = 5'b00001;
        default: s = 5'b00000;
      endcase
    end
    return s;
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // One dclk period (5 low, 5 high). ack_mode: 0 none, 1 pulse while low, 2 with the rise.
  task automatic step(input logic mw, input int ack_mode, input logic hlt,
                      input logic [2:0] ph, input string tag);
    logic [2:0] want;
    logic [4:0] stb;
    exp_q.push_back(ph);
    @(negedge clk);
    bus.dclk = 1'b0; bus.MW = mw; bus.halt = hlt; bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    if (ack_mode == 1) bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    bus.dclk = 1'b1;
    if (ack_mode == 2) bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    want = exp_q.pop_front();
    stb  = exp_strobe(m_phase, want);
    chk({tag, " phase"}, int'(bus.phase), int'(want));
    chk({tag, " strobes"}, int'(strobes()), int'(stb));
    chk({tag, " busy"}, int'(bus.busy), int'(want != 3'd0 && want != 3'd6));
    chk({tag, " count"}, int'(bus.instr_count), n_done % 256);
    m_phase = want;
    @(negedge clk);
    chk({tag, " strobe width"}, int'(strobes()), 0);
    chk({tag, " phase held"}, int'(bus.phase), int'(want));
    repeat (2) @(negedge clk);
  endtask

  task automatic add(input logic mw, input int ack, input logic hlt,
                     input logic [2:0] ph, input int cnt);
    vec_t v;
    v.mw = mw; v.ack = ack; v.hlt = hlt; v.ph = ph; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // One instruction starting in FETCH, with noise on inputs that must be ignored.
  task automatic run_instr();
    logic mw;
    int   d;
    int   h;
    step(rnd1(), $urandom_range(0, 2), rnd1(), 3'd2, "rnd dec");
    step(rnd1(), $urandom_range(0, 2), rnd1(), 3'd3, "rnd exe");
    mw = rnd1();
    step(mw, $urandom_range(0, 2), rnd1(), mw ? 3'd4 : 3'd5, "rnd exit");
    if (mw) begin
      d = $urandom_range(0, 3);
      repeat (d) step(rnd1(), 0, rnd1(), 3'd4, "rnd memwait");
      step(rnd1(), $urandom_range(1, 2), rnd1(), 3'd5, "rnd memack");
    end
    h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    n_done++;
    step(rnd1(), $urandom_range(0, 2), h > 0, (h > 0) ? 3'd6 : 3'd1, "rnd wb");
    if (h > 0) begin
      repeat (h - 1) step(rnd1(), $urandom_range(0, 2), 1'b1, 3'd6, "rnd halted");
      step(rnd1(), $urandom_range(0, 2), 1'b0, 3'd1, "rnd resume");
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.dclk = 1'b0; bus.MW = 1'b0; bus.mem_ack = 1'b0; bus.halt = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset phase", int'(bus.phase), 0);
    chk("reset strobes", int'(strobes()), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset count", int'(bus.instr_count), 0);
    rst_n = 1'b1;

    // mw, ack_mode, halt, expected phase after the tick, expected instr_count
    add(0, 0, 0, 3'd0, 0);
    add(0, 0, 0, 3'd1, 0);
    add(0, 0, 0, 3'd2, 0);
    add(0, 0, 0, 3'd3, 0);
    add(0, 0, 0, 3'd5, 0);
    add(1, 0, 0, 3'd1, 1);
    add(0, 1, 0, 3'd2, 1);
    add(0, 0, 1, 3'd3, 1);
    add(1, 0, 0, 3'd4, 1);
    add(0, 1, 0, 3'd5, 1);
    add(0, 0, 0, 3'd1, 2);
    add(0, 0, 0, 3'd2, 2);
    add(0, 1, 0, 3'd3, 2);
    add(1, 2, 0, 3'd4, 2);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 3'd4, 2);
    add(0, 2, 0, 3'd5, 2);
    add(0, 0, 1, 3'd6, 3);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 3'd6, 3);
    add(0, 0, 0, 3'd1, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      n_done = tbl[i].cnt;
      step(tbl[i].mw, tbl[i].ack, tbl[i].hlt, tbl[i].ph, $sformatf("vec%0d", i));
    end

    // Enough instructions to carry instr_count through 255 -> 0.
    for (int i = 0; i < 260; i++) run_instr();
    chk("count wrapped", int'(bus.instr_count), n_done % 256);

    step(0, 0, 0, 3'd2, "pre dec");
    step(0, 0, 0, 3'd3, "pre exe");
    step(1, 0, 0, 3'd4, "pre mem");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async phase", int'(bus.phase), 0);
    chk("async strobes", int'(strobes()), 0);
    chk("async busy", int'(bus.busy), 0);
    chk("async count", int'(bus.instr_count), 0);
    m_phase = 3'd0;
    n_done  = 0;
    bus.dclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    bus.dclk = 1'b1;
    repeat (4) @(negedge clk);
    chk("release high phase", int'(bus.phase), 0);
    chk("release high busy", int'(bus.busy), 0);
    step(0, 0, 0, 3'd0, "post rst tick1");
    step(0, 0, 0, 3'd1, "post rst tick2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
